// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: emits the binary index of every set bit of an accepted vector,
// lowest first, one code per output handshake, with op_last on the final code.
// Optional macro ENC_ZERO_FLAG_EN: an all-zero vector yields one beat flagged by zero_flag.
module encoder_8to3_seq #(
  parameter int N_IN  = 8,
  parameter int W_OUT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  inp,
  input  logic             inp_valid,
  output logic             inp_ready,
  output logic [W_OUT-1:0] op,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             op_last
`ifdef ENC_ZERO_FLAG_EN
  ,
  output logic             zero_flag
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [N_IN-1:0] ONE = N_IN'(1);

  state_t           state, state_nxt;
  logic [N_IN-1:0]  pend, pend_nxt;
  logic [W_OUT-1:0] op_nxt;
  logic             op_valid_nxt;
  logic             op_last_nxt;
`ifdef ENC_ZERO_FLAG_EN
  logic             zero_q, zero_nxt;
  assign zero_flag = zero_q;
`endif

  // Index of the lowest set bit; scanning downward lets the lowest hit win.
  function automatic logic [W_OUT-1:0] lowest_idx(input logic [N_IN-1:0] v);
    lowest_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = W_OUT'(i);
    end
  endfunction

  // True when exactly one bit is set: nonzero and clearing the lowest bit leaves nothing.
  function automatic logic single_bit(input logic [N_IN-1:0] v);
    single_bit = (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  assign inp_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Output and pending-bit registers; reset discards any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      op_last  <= 1'b0;
`ifdef ENC_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      pend     <= pend_nxt;
      op       <= op_nxt;
      op_valid <= op_valid_nxt;
      op_last  <= op_last_nxt;
`ifdef ENC_ZERO_FLAG_EN
      zero_q   <= zero_nxt;
`endif
    end
  end

  // Next-state and next-output: hold everything unless a vector is taken or a code is consumed.
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    op_nxt       = op;
    op_valid_nxt = op_valid;
    op_last_nxt  = op_last;
`ifdef ENC_ZERO_FLAG_EN
    zero_nxt     = zero_q;
`endif
    case (state)
      IDLE: begin
        if (inp_valid) begin
          if (inp != '0) begin
            op_nxt       = lowest_idx(inp);
            op_valid_nxt = 1'b1;
            op_last_nxt  = single_bit(inp);
            pend_nxt     = inp & (inp - ONE);
            state_nxt    = BUSY;
`ifdef ENC_ZERO_FLAG_EN
            zero_nxt     = 1'b0;
`endif
          end else begin
`ifdef ENC_ZERO_FLAG_EN
            op_nxt       = '0;
            op_valid_nxt = 1'b1;
            op_last_nxt  = 1'b1;
            pend_nxt     = '0;
            zero_nxt     = 1'b1;
            state_nxt    = BUSY;
`else
            // Empty vector is consumed and dropped without an output beat.
            state_nxt    = IDLE;
`endif
          end
        end
      end
      BUSY: begin
        if (op_ready) begin
          if (pend != '0) begin
            op_nxt      = lowest_idx(pend);
            op_last_nxt = single_bit(pend);
            pend_nxt    = pend & (pend - ONE);
`ifdef ENC_ZERO_FLAG_EN
            zero_nxt    = 1'b0;
`endif
          end else begin
            // Final code consumed; op keeps its last value, one bubble before next vector.
            op_valid_nxt = 1'b0;
            op_last_nxt  = 1'b0;
            state_nxt    = IDLE;
`ifdef ENC_ZERO_FLAG_EN
            zero_nxt     = 1'b0;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Testbench for encoder_8to3_seq: directed vectors feed a queue of expected codes,
// a negedge monitor pops and compares each output beat and checks decoder loopback.
module tb_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inp;
  logic       inp_valid;
  logic       inp_ready;
  logic [2:0] op;
  logic       op_valid;
  logic       op_ready;
  logic       op_last;
`ifdef ENC_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  encoder_8to3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .inp_valid (inp_valid),
    .inp_ready (inp_ready),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_last   (op_last)
`ifdef ENC_ZERO_FLAG_EN
    ,
    .zero_flag (zero_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic       last;
    logic       zf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] vec_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] acc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] code, input logic last, input logic zf);
    exp_t e;
    e.code = code;
    e.last = last;
    e.zf   = zf;
    exp_q.push_back(e);
  endtask

  // Present one vector for a single accepting cycle.
  task automatic send(input logic [7:0] v);
    int waited = 0;
    while (!inp_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("send_ready", 32'(inp_ready), 32'd1);
    vec_q.push_back(v);
    inp       = v;
    inp_valid = 1'b1;
    tick();
    inp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (!(inp_ready && !op_valid) && waited < 50) begin
      tick();
      waited++;
    end
    check("idle_timeout", 32'(inp_ready && !op_valid), 32'd1);
  endtask

  // Monitor: a beat is transferred when valid and ready are both high outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = '0;
      end else if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(op), 32'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("op", 32'(op), 32'(e.code));
          check("op_last", 32'(op_last), 32'(e.last));
`ifdef ENC_ZERO_FLAG_EN
          check("zero_flag", 32'(zero_flag), 32'(e.zf));
`endif
          acc = acc | (8'd1 << op);
          if (op_last) begin
            if (vec_q.size() != 0) begin
              logic [7:0] v;
              v = vec_q.pop_front();
              if (v != 8'd0) check("loopback", 32'(acc), 32'(v));
            end
            acc = '0;
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    inp       = '0;
    inp_valid = 1'b0;
    op_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_op_last", 32'(op_last), 32'd0);
    check("rst_inp_ready", 32'(inp_ready), 32'd1);

    // Reset wins over an offered vector
    inp = 8'h0F; inp_valid = 1'b1; rst = 1'b1;
    tick();
    inp_valid = 1'b0; rst = 1'b0;
    check("rst_cap_valid", 32'(op_valid), 32'd0);
    check("rst_cap_ready", 32'(inp_ready), 32'd1);
    tick();
    check("rst_cap_valid2", 32'(op_valid), 32'd0);

    // Single bit 0: one-cycle latency, then bubble
    push_exp(3'd0, 1'b1, 1'b0);
    send(8'h01);
    check("t2_valid", 32'(op_valid), 32'd1);
    check("t2_op", 32'(op), 32'd0);
    check("t2_last", 32'(op_last), 32'd1);
    check("t2_busy", 32'(inp_ready), 32'd0);
    tick();
    check("t2_drop", 32'(op_valid), 32'd0);
    check("t2_ready", 32'(inp_ready), 32'd1);

    // One-hot sweep
    for (int k = 0; k < 8; k++) begin
      push_exp(3'(k), 1'b1, 1'b0);
      send(8'd1 << k);
      wait_idle();
    end

    // Multi-hot 1010_0100 -> 2,5,7; inp_valid while busy is ignored
    push_exp(3'd2, 1'b0, 1'b0);
    push_exp(3'd5, 1'b0, 1'b0);
    push_exp(3'd7, 1'b1, 1'b0);
    send(8'b1010_0100);
    check("t4_busy0", 32'(inp_ready), 32'd0);
    inp = 8'h01; inp_valid = 1'b1;
    tick();
    inp_valid = 1'b0;
    check("t4_busy1", 32'(inp_ready), 32'd0);
    tick();
    check("t4_busy2", 32'(inp_ready), 32'd0);
    check("t4_op7", 32'(op), 32'd7);
    wait_idle();

    // Backpressure hold
    op_ready = 1'b0;
    push_exp(3'd3, 1'b0, 1'b0);
    push_exp(3'd4, 1'b1, 1'b0);
    send(8'b0001_1000);
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", 32'(op_valid), 32'd1);
      check("t5_hold_op", 32'(op), 32'd3);
      check("t5_hold_last", 32'(op_last), 32'd0);
      tick();
    end
    op_ready = 1'b1;
    wait_idle();

    // Reset mid-burst
    push_exp(3'd0, 1'b0, 1'b0);
    push_exp(3'd1, 1'b0, 1'b0);
    send(8'hFF);
    tick();
    tick();
    check("t6_op2", 32'(op), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", 32'(op_valid), 32'd0);
    check("t6_rst_ready", 32'(inp_ready), 32'd1);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    vec_q.delete();
    push_exp(3'd7, 1'b1, 1'b0);
    send(8'h80);
    wait_idle();

    // Zero vector
`ifdef ENC_ZERO_FLAG_EN
    push_exp(3'd0, 1'b1, 1'b1);
    send(8'h00);
    check("zero_valid", 32'(op_valid), 32'd1);
    wait_idle();
`else
    send(8'h00);
    check("zero_no_valid", 32'(op_valid), 32'd0);
    check("zero_ready", 32'(inp_ready), 32'd1);
    tick();
    check("zero_no_valid2", 32'(op_valid), 32'd0);
`endif

    tick();
    tick();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
